// File: rtl/if_fetch_queue.sv
// Fetch stage: PC generator, in-order imem request/response handshake and a fetch queue toward ID.
// Optional misaligned-redirect marker support is enabled by defining IF_MISALIGN_CHECK_EN.
module if_fetch_queue #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     FQ_DEPTH        = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [31:0]     id_instr,
  output logic            id_misaligned
);

  localparam int unsigned FQ_AW = $clog2(FQ_DEPTH);
  localparam int unsigned FQ_CW = FQ_AW + 1;
  localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PF_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]    out_q, out_d;
  logic [OW-1:0]    stale_q, stale_d;
  logic [FQ_AW-1:0] fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
  logic [FQ_CW-1:0] fq_cnt_q, fq_cnt_d;
  logic [PF_AW-1:0] pf_rd_q, pf_rd_d, pf_wr_q, pf_wr_d;

  logic [XLEN-1:0]  fq_pc_q    [FQ_DEPTH];
  logic [31:0]      fq_instr_q [FQ_DEPTH];
  logic [XLEN-1:0]  pf_pc_q    [MAX_OUTSTANDING];

  logic             push, pf_push;
  logic [XLEN-1:0]  push_pc;
  logic [31:0]      push_instr;
  logic             push_mis;

  logic             credit_ok_c, fetch_block_c, req_valid_c, accept_c;
  logic             head_valid_c, pop_c;
  logic [XLEN-1:0]  redir_pc_c;

`ifdef IF_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {MS_RUN, MS_WAIT, MS_HALT} mis_state_e;
  mis_state_e ms_q, ms_d;
  logic       fq_mis_q [FQ_DEPTH];

  assign redir_pc_c    = redirect_pc;
  assign fetch_block_c = (ms_q != MS_RUN);
`else
  assign redir_pc_c    = redirect_pc & ALIGN_MASK;
  assign fetch_block_c = 1'b0;
`endif

  // Credit counts in-flight requests (including stale ones) against free queue slots.
  assign credit_ok_c  = (out_q < OW'(MAX_OUTSTANDING)) &&
                        ((32'(out_q) + 32'(fq_cnt_q)) < FQ_DEPTH);
  assign req_valid_c  = reset && !redirect_valid && !fetch_block_c && credit_ok_c;
  assign accept_c     = req_valid_c && imem_req_ready;
  assign head_valid_c = reset && (fq_cnt_q != '0);
  assign pop_c        = head_valid_c && id_ready;

  assign imem_req_valid = req_valid_c;
  assign imem_req_addr  = fetch_pc_q & ALIGN_MASK;
  assign id_valid       = head_valid_c;
  assign id_pc          = head_valid_c ? fq_pc_q[fq_rd_q] : '0;
  assign id_pc_plus4    = head_valid_c ? fq_pc_q[fq_rd_q] + XLEN'(4) : '0;
  assign id_instr       = head_valid_c ? fq_instr_q[fq_rd_q] : '0;
`ifdef IF_MISALIGN_CHECK_EN
  assign id_misaligned  = head_valid_c && fq_mis_q[fq_rd_q];
`else
  assign id_misaligned  = 1'b0;
`endif

  // Next-state: redirect wins over accept, response push and pop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    stale_d    = stale_q;
    fq_rd_d    = fq_rd_q;
    fq_wr_d    = fq_wr_q;
    fq_cnt_d   = fq_cnt_q;
    pf_rd_d    = pf_rd_q;
    pf_wr_d    = pf_wr_q;
    push       = 1'b0;
    pf_push    = 1'b0;
    push_pc    = '0;
    push_instr = '0;
    push_mis   = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    ms_d       = ms_q;
`endif
    if (redirect_valid) begin
      fetch_pc_d = redir_pc_c;
      out_d      = out_q - OW'(imem_rsp_valid);
      stale_d    = out_q - OW'(imem_rsp_valid);
      fq_rd_d    = '0;
      fq_wr_d    = '0;
      fq_cnt_d   = '0;
      pf_rd_d    = '0;
      pf_wr_d    = '0;
`ifdef IF_MISALIGN_CHECK_EN
      ms_d       = (redirect_pc[1:0] != 2'b00) ? MS_WAIT : MS_RUN;
`endif
    end else begin
      if (accept_c) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        pf_push    = 1'b1;
        pf_wr_d    = (pf_wr_q == PF_AW'(MAX_OUTSTANDING - 1)) ? '0 : pf_wr_q + PF_AW'(1);
      end
      out_d = out_q + OW'(accept_c) - OW'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (stale_q != '0) begin
          stale_d = stale_q - OW'(1);
        end else begin
          push       = 1'b1;
          push_pc    = pf_pc_q[pf_rd_q];
          push_instr = imem_rsp_data;
          pf_rd_d    = (pf_rd_q == PF_AW'(MAX_OUTSTANDING - 1)) ? '0 : pf_rd_q + PF_AW'(1);
        end
      end
`ifdef IF_MISALIGN_CHECK_EN
      // Marker waits until every pre-redirect response has drained.
      else if (ms_q == MS_WAIT && out_q == '0 && stale_q == '0) begin
        push       = 1'b1;
        push_pc    = fetch_pc_q;
        push_instr = 32'h0000_0013;
        push_mis   = 1'b1;
        ms_d       = MS_HALT;
      end
`endif
      if (push) begin
        fq_wr_d = fq_wr_q + FQ_AW'(1);
      end
      if (pop_c) begin
        fq_rd_d = fq_rd_q + FQ_AW'(1);
      end
      fq_cnt_d = fq_cnt_q + FQ_CW'(push) - FQ_CW'(pop_c);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      stale_q    <= '0;
      fq_rd_q    <= '0;
      fq_wr_q    <= '0;
      fq_cnt_q   <= '0;
      pf_rd_q    <= '0;
      pf_wr_q    <= '0;
`ifdef IF_MISALIGN_CHECK_EN
      ms_q       <= MS_RUN;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      stale_q    <= stale_d;
      fq_rd_q    <= fq_rd_d;
      fq_wr_q    <= fq_wr_d;
      fq_cnt_q   <= fq_cnt_d;
      pf_rd_q    <= pf_rd_d;
      pf_wr_q    <= pf_wr_d;
`ifdef IF_MISALIGN_CHECK_EN
      ms_q       <= ms_d;
`endif
    end
  end

  // Payload storage; validity is tracked solely by the pointers above.
  always_ff @(posedge clk) begin
    if (pf_push) begin
      pf_pc_q[pf_wr_q] <= fetch_pc_q & ALIGN_MASK;
    end
    if (push) begin
      fq_pc_q[fq_wr_q]    <= push_pc;
      fq_instr_q[fq_wr_q] <= push_instr;
`ifdef IF_MISALIGN_CHECK_EN
      fq_mis_q[fq_wr_q]   <= push_mis;
`endif
    end
  end

`ifndef IF_MISALIGN_CHECK_EN
  logic unused_ok;
  assign unused_ok = push_mis;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a fixed-latency in-order imem model.
module tb_if_fetch_queue;

  localparam logic [31:0] IKEY = 32'h1357_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        id_misaligned;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t mq[$];

  if_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_instr       (id_instr),
    .id_misaligned  (id_misaligned)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // imem: records accepts at mid-cycle, answers in order after lat cycles.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mq.delete();
      end else begin
        if (imem_rsp_valid) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
      end
      @(posedge clk);
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq[0].addr ^ IKEY;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  task automatic do_reset(input int l);
    lat            = l;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valids: req_valid=%b id_valid=%b, want 0 0", imem_req_valid, id_valid);
    end
    total++;
    if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin
      bad++;
      $display("FAIL reset_pc: id_pc=%h id_pc_plus4=%h, want 0 0", id_pc, id_pc_plus4);
    end
    total++;
    if (id_instr !== 32'h0 || id_misaligned !== 1'b0) begin
      bad++;
      $display("FAIL reset_instr: id_instr=%h mis=%b, want 0 0", id_instr, id_misaligned);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset(1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
        bad++;
        $display("FAIL stream_req k=%0d: valid=%b addr=%h, want 1 %h", k, imem_req_valid, imem_req_addr, 32'(4 * k));
      end
      if (k < 2) begin
        total++;
        if (id_valid !== 1'b0) begin
          bad++;
          $display("FAIL stream_early k=%0d: id_valid=%b, want 0", k, id_valid);
        end
      end else begin
        exp = 32'(4 * (k - 2));
        total++;
        if (id_valid !== 1'b1 || id_pc !== exp) begin
          bad++;
          $display("FAIL stream_id k=%0d: valid=%b pc=%h, want 1 %h", k, id_valid, id_pc, exp);
        end
        total++;
        if (id_pc_plus4 !== exp + 32'd4 || id_instr !== (exp ^ IKEY) || id_misaligned !== 1'b0) begin
          bad++;
          $display("FAIL stream_data k=%0d: plus4=%h instr=%h mis=%b, want %h %h 0",
                   k, id_pc_plus4, id_instr, id_misaligned, exp + 32'd4, exp ^ IKEY);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    do_reset(1);
    id_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      id_ready = (k >= 10);
      @(negedge clk);
      if (k >= 4 && k <= 10) begin
        total++;
        if (imem_req_valid !== 1'b0) begin
          bad++;
          $display("FAIL bp_credit k=%0d: req_valid=%b, want 0", k, imem_req_valid);
        end
      end
      if (k == 9) begin
        total++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
          bad++;
          $display("FAIL bp_hold: valid=%b pc=%h, want 1 0", id_valid, id_pc);
        end
      end
      if (k >= 10) begin
        exp = 32'(4 * (k - 10));
        total++;
        if (id_valid !== 1'b1 || id_pc !== exp || id_instr !== (exp ^ IKEY)) begin
          bad++;
          $display("FAIL bp_drain k=%0d: valid=%b pc=%h instr=%h, want 1 %h %h",
                   k, id_valid, id_pc, id_instr, exp, exp ^ IKEY);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_redirect_flush();
    do_reset(3);
    for (int k = 0; k < 10; k++) begin
      redirect_valid = (k == 2);
      redirect_pc    = 32'h100;
      @(negedge clk);
      if (k == 2 || k == 3) begin
        total++;
        if (imem_req_valid !== 1'b0) begin
          bad++;
          $display("FAIL flush_noreq k=%0d: req_valid=%b, want 0", k, imem_req_valid);
        end
      end
      if (k == 4) begin
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
          bad++;
          $display("FAIL flush_req: valid=%b addr=%h, want 1 00000100", imem_req_valid, imem_req_addr);
        end
      end
      if (k >= 3 && k <= 7) begin
        total++;
        if (id_valid !== 1'b0) begin
          bad++;
          $display("FAIL flush_empty k=%0d: id_valid=%b pc=%h, want 0", k, id_valid, id_pc);
        end
      end
      if (k >= 8) begin
        total++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 + 32'(4 * (k - 8))) begin
          bad++;
          $display("FAIL flush_target k=%0d: valid=%b pc=%h, want 1 %h", k, id_valid, id_pc, 32'h100 + 32'(4 * (k - 8)));
        end
      end
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_redirect_collide();
    do_reset(1);
    for (int k = 0; k < 7; k++) begin
      redirect_valid = (k == 2);
      redirect_pc    = 32'h200;
      @(negedge clk);
      if (k == 2) begin
        total++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || imem_req_valid !== 1'b0) begin
          bad++;
          $display("FAIL collide_cycle: id_valid=%b pc=%h req_valid=%b, want 1 0 0", id_valid, id_pc, imem_req_valid);
        end
      end
      if (k == 3) begin
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
          bad++;
          $display("FAIL collide_req: valid=%b addr=%h, want 1 00000200", imem_req_valid, imem_req_addr);
        end
      end
      if (k == 3 || k == 4) begin
        total++;
        if (id_valid !== 1'b0) begin
          bad++;
          $display("FAIL collide_empty k=%0d: id_valid=%b pc=%h, want 0", k, id_valid, id_pc);
        end
      end
      if (k >= 5) begin
        total++;
        if (id_valid !== 1'b1 || id_pc !== 32'h200 + 32'(4 * (k - 5))) begin
          bad++;
          $display("FAIL collide_target k=%0d: valid=%b pc=%h, want 1 %h", k, id_valid, id_pc, 32'h200 + 32'(4 * (k - 5)));
        end
      end
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    id_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 5) reset = 1'b0;
      if (k == 7) begin
        reset    = 1'b1;
        id_ready = 1'b1;
      end
      @(negedge clk);
      if (k == 4) begin
        total++;
        if (id_valid !== 1'b1) begin
          bad++;
          $display("FAIL rstmid_pre: id_valid=%b, want 1", id_valid);
        end
      end
      if (k == 5) begin
        total++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || id_pc !== 32'h0) begin
          bad++;
          $display("FAIL rstmid_low: id_valid=%b req_valid=%b pc=%h, want 0 0 0", id_valid, imem_req_valid, id_pc);
        end
      end
      if (k == 7 || k == 8) begin
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * (k - 7))) begin
          bad++;
          $display("FAIL rstmid_restart k=%0d: valid=%b addr=%h, want 1 %h", k, imem_req_valid, imem_req_addr, 32'(4 * (k - 7)));
        end
      end
      if (k == 9) begin
        total++;
        if (id_valid !== 1'b0) begin
          bad++;
          $display("FAIL rstmid_gap: id_valid=%b pc=%h, want 0", id_valid, id_pc);
        end
      end
      if (k == 10 || k == 11) begin
        total++;
        if (id_valid !== 1'b1 || id_pc !== 32'(4 * (k - 10))) begin
          bad++;
          $display("FAIL rstmid_id k=%0d: valid=%b pc=%h, want 1 %h", k, id_valid, id_pc, 32'(4 * (k - 10)));
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef IF_MISALIGN_CHECK_EN
  task automatic test_misalign();
    do_reset(1);
    for (int k = 0; k < 13; k++) begin
      redirect_valid = (k == 2 || k == 8);
      redirect_pc    = (k == 2) ? 32'h102 : 32'h200;
      @(negedge clk);
      if (k >= 3 && k <= 8) begin
        total++;
        if (imem_req_valid !== 1'b0) begin
          bad++;
          $display("FAIL mis_halt k=%0d: req_valid=%b, want 0", k, imem_req_valid);
        end
      end
      if (k == 3 || (k >= 5 && k <= 7)) begin
        total++;
        if (id_valid !== 1'b0) begin
          bad++;
          $display("FAIL mis_empty k=%0d: id_valid=%b pc=%h, want 0", k, id_valid, id_pc);
        end
      end
      if (k == 4) begin
        total++;
        if (id_valid !== 1'b1 || id_pc !== 32'h102 || id_pc_plus4 !== 32'h106 ||
            id_instr !== 32'h0000_0013 || id_misaligned !== 1'b1) begin
          bad++;
          $display("FAIL mis_marker: valid=%b pc=%h p4=%h instr=%h mis=%b, want 1 00000102 00000106 00000013 1",
                   id_valid, id_pc, id_pc_plus4, id_instr, id_misaligned);
        end
      end
      if (k == 9) begin
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
          bad++;
          $display("FAIL mis_resume: valid=%b addr=%h, want 1 00000200", imem_req_valid, imem_req_addr);
        end
      end
      if (k == 11) begin
        total++;
        if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_misaligned !== 1'b0) begin
          bad++;
          $display("FAIL mis_after: valid=%b pc=%h mis=%b, want 1 00000200 0", id_valid, id_pc, id_misaligned);
        end
      end
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
  endtask
`else
  task automatic test_force_align();
    do_reset(1);
    for (int k = 0; k < 7; k++) begin
      redirect_valid = (k == 2);
      redirect_pc    = 32'h302;
      @(negedge clk);
      if (k == 3) begin
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
          bad++;
          $display("FAIL align_req: valid=%b addr=%h, want 1 00000300", imem_req_valid, imem_req_addr);
        end
      end
      if (k == 5 || k == 6) begin
        total++;
        if (id_valid !== 1'b1 || id_pc !== 32'h300 + 32'(4 * (k - 5)) || id_misaligned !== 1'b0) begin
          bad++;
          $display("FAIL align_id k=%0d: valid=%b pc=%h mis=%b, want 1 %h 0",
                   k, id_valid, id_pc, id_misaligned, 32'h300 + 32'(4 * (k - 5)));
        end
      end
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_collide();
    test_reset_mid();
`ifdef IF_MISALIGN_CHECK_EN
    test_misalign();
`else
    test_force_align();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the single-cycle fetch stage: fetch PC generator plus a request/response handshake to a variable-latency, in-order instruction memory, and an FQ_DEPTH-entry fetch queue feeding ID over valid/ready.
- Redirects from EX (branch/jump/flush) restart fetch. Responses already in flight are discarded by a stale-response counter.
- Sits between the PC/redirect logic and the IF/ID boundary and replaces the combinational imem path.

Parameters:
- XLEN, 32, data/address width.
- FQ_DEPTH, 4, fetch queue entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum imem requests in flight (>=1).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- redirect_valid  in  1  EX redirect (branch taken / flush).
- redirect_pc  in  XLEN  redirect target (byte address).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  imem accepts request.
- imem_req_addr  out  XLEN  word-aligned byte address of request.
- imem_rsp_valid  in  1  instruction returned. In-order, one per accepted request, no backpressure.
- imem_rsp_data  in  32  instruction word.
- id_valid  out  1  queue head valid.
- id_ready  in  1  ID consumes head (low = hazard stall).
- id_pc  out  XLEN  PC of head.
- id_pc_plus4  out  XLEN  id_pc + 4.
- id_instr  out  32  instruction of head.
- id_misaligned  out  1  head is a misaligned-fetch marker; tied 0 unless the macro is defined.

Behaviour:
- Reset (reset==0 at an edge):
  - fetch_pc = RESET_PC; queue empty; outstanding = 0; stale = 0.
  - imem_req_valid = 0 and id_valid = 0 while reset is low. id_pc, id_pc_plus4, id_instr and id_misaligned read 0.
  - Reset mid-transaction abandons everything. The imem side is reset together with this block.
- Issue:
  - imem_req_valid = !redirect_valid && outstanding < MAX_OUTSTANDING && (outstanding + fq_count) < FQ_DEPTH.
  - This credit rule guarantees every response has a free queue slot, so responses need no backpressure.
  - imem_req_addr = {fetch_pc[XLEN-1:2], 2'b00}.
  - On req accept (valid && ready): fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
- Response:
  - On imem_rsp_valid: outstanding -= 1.
  - If stale > 0: stale -= 1 and drop the data.
  - Otherwise push {pc, pc+4, data} into the queue. pc comes from a parallel PC FIFO of depth MAX_OUTSTANDING, written on accept and read on response.
  - A simultaneous accept and response leaves outstanding unchanged.
- Dequeue:
  - Head is presented combinationally from queue storage.
  - Pop when id_valid && id_ready. Push and pop in the same cycle keep fq_count unchanged; both are allowed at full and at empty+push (no bypass).
- Redirect (redirect_valid==1 in cycle T):
  - Queue flushed and PC FIFO cleared at T's edge; fetch_pc = redirect_pc.
  - stale = outstanding minus (1 if a response arrives in T), since the response in T is itself dropped. No request is issued in T.
  - Redirect has priority over same-cycle pop, push and accept.
- Latency:
  - Redirect at T gives a request at T+1.
  - With 1-cycle imem (rsp at T+2), id_valid rises at T+3.
  - Steady-state throughput is 1 instr/cycle when MAX_OUTSTANDING >= imem latency + 1.
- Full queue: requests stop until a pop frees credit. id_ready low for any duration loses nothing.
- Consecutive redirects: each recomputes stale from the live outstanding count; the last one wins.

Optional Feature:
- Macro IF_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 issues no requests.
  - It pushes one marker entry once outstanding==0 && stale==0: id_pc = redirect_pc, id_instr = 32'h0000_0013, id_misaligned = 1.
  - Fetch then halts (imem_req_valid = 0) until the next redirect.
- Undefined: redirect_pc[1:0] is forced to 0 and id_misaligned is tied 0.

Test Plan:
- Release reset, imem 1-cycle always-ready, id_ready = 1 -> requests at 0x0, 0x4, 0x8..., id_valid from 3rd cycle after reset release, one entry/cycle, id_pc_plus4 = id_pc + 4.
- id_ready = 0 for 10 cycles, FQ_DEPTH = 4 -> exactly 4 entries queued, imem_req_valid low while fq_count + outstanding == 4. Release id_ready -> PCs 0x0..0xC delivered in order with no loss or duplicate.
- imem 3-cycle latency, 2 requests in flight, redirect_pc = 0x100 -> both old responses dropped, queue empty, next id_pc = 0x100.
- Redirect in the same cycle as imem_rsp_valid and an id pop -> response dropped, pop ignored, stale = outstanding - 1, next delivered id_pc = redirect target.
- Drive reset low mid-stream with 2 outstanding -> id_valid = 0 and imem_req_valid = 0 the next cycle. After release, fetch restarts at RESET_PC.
- IF_MISALIGN_CHECK_EN defined, redirect_pc = 0x102 -> one entry, id_misaligned = 1, id_instr = 0x00000013, no requests until redirect to 0x200.
